// File: rtl/alu_adder_hold.sv
// alu_adder_hold: two-stage ALU adder with hold register; ALU_DECIMAL_MODE_EN adds BCD adjust for DAA/DSA
module alu_adder_hold (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] SB,
  input  logic [7:0] DB,
  input  logic [7:0] ADL,
  input  logic       SB_ADD,
  input  logic       O_ADD,
  input  logic       DB_ADD,
  input  logic       DB_N_ADD,
  input  logic       ADL_ADD,
  input  logic       SUMS,
  input  logic       ANDS,
  input  logic       EORS,
  input  logic       ORS,
  input  logic       SRS,
  input  logic       I_ADDC,
  input  logic       DAA,
  input  logic       DSA,
  output logic [7:0] Adder_Hold_Register_Out,
  output logic       ACR,
  output logic       AVR,
  output logic       Result_Valid
);
  typedef enum logic [2:0] {OP_SUM, OP_AND, OP_EOR, OP_OR, OP_SR} op_e;
  logic [7:0] a, b, and_r, sum_r, res;
  logic [8:0] sum9;
  logic       pend, cin, strobe, sum_c, sum_v, res_c, res_v;
  op_e        op, op_nx;
  assign strobe = SUMS | ANDS | EORS | ORS | SRS;
  assign op_nx  = SUMS ? OP_SUM : ANDS ? OP_AND : EORS ? OP_EOR : ORS ? OP_OR : OP_SR;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a    <= 8'h00;
      b    <= 8'h00;
      pend <= 1'b0;
      op   <= OP_SUM;
      cin  <= 1'b0;
    end else begin
      if (O_ADD | SB_ADD) a <= O_ADD ? 8'h00 : SB;
      if (DB_ADD | DB_N_ADD | ADL_ADD) b <= DB_ADD ? DB : DB_N_ADD ? ~DB : ADL;
      pend <= strobe;
      if (strobe) begin
        op  <= op_nx;
        cin <= I_ADDC;
      end
    end
  end
  assign sum9  = {1'b0, a} + {1'b0, b} + {8'b0, cin};
  assign and_r = a & b;
  assign sum_v = ~(a[7] ^ b[7]) & (sum9[7] ^ a[7]);
`ifdef ALU_DECIMAL_MODE_EN
  logic       daa, dsa, lo_adj, hi_adj;
  logic [4:0] lo;
  logic [8:0] t9;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      daa <= 1'b0;
      dsa <= 1'b0;
    end else if (strobe) begin
      daa <= DAA & ~DSA;
      dsa <= DSA & ~DAA;
    end
  end
  // nibble carry comes from the raw operands, not the binary sum
  assign lo     = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
  assign lo_adj = lo[4] | (sum9[3:0] > 4'd9);
  assign t9     = sum9 + (lo_adj ? 9'h006 : 9'h000);
  assign hi_adj = sum9[8] | (t9 > 9'h09F);
  assign sum_r  = daa ? t9[7:0] + (hi_adj ? 8'h60 : 8'h00)
                : dsa ? sum9[7:0] - (lo[4] ? 8'h00 : 8'h06) - (sum9[8] ? 8'h00 : 8'h60)
                : sum9[7:0];
  assign sum_c  = daa ? hi_adj : sum9[8];
`else
  logic unused_dec;
  assign unused_dec = DAA ^ DSA;
  assign sum_r      = sum9[7:0];
  assign sum_c      = sum9[8];
`endif
  assign res   = op == OP_SUM ? sum_r : op == OP_AND ? and_r : op == OP_EOR ? a ^ b
               : op == OP_OR ? a | b : {cin, and_r[7:1]};
  assign res_c = op == OP_SUM ? sum_c : op == OP_SR ? and_r[0] : 1'b0;
  assign res_v = (op == OP_SUM) & sum_v;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Adder_Hold_Register_Out <= 8'h00;
      ACR                     <= 1'b0;
      AVR                     <= 1'b0;
      Result_Valid            <= 1'b0;
    end else begin
      Result_Valid <= pend;
      if (pend) begin
        Adder_Hold_Register_Out <= res;
        ACR                     <= res_c;
        AVR                     <= res_v;
      end
    end
  end
endmodule

// File: tb/tb_alu_adder_hold.sv
// tb_alu_adder_hold: directed spec vectors plus random traffic against an integer reference model
module tb_alu_adder_hold;
  logic       clk = 0, reset = 0;
  logic [7:0] SB = 0, DB = 0, ADL = 0;
  logic       SB_ADD = 0, O_ADD = 0, DB_ADD = 0, DB_N_ADD = 0, ADL_ADD = 0;
  logic       SUMS = 0, ANDS = 0, EORS = 0, ORS = 0, SRS = 0;
  logic       I_ADDC = 0, DAA = 0, DSA = 0;
  logic [7:0] out;
  logic       ACR, AVR, Result_Valid;
  int passed = 0, total = 0;
  int ma = 0, mb = 0, pop = 0, pcin = 0, pdaa = 0, pdsa = 0;
  bit pend = 0;
  int eo = 0, ec = 0, ev = 0, erv = 0;

  alu_adder_hold dut (
    .clk(clk), .reset(reset), .SB(SB), .DB(DB), .ADL(ADL),
    .SB_ADD(SB_ADD), .O_ADD(O_ADD), .DB_ADD(DB_ADD), .DB_N_ADD(DB_N_ADD), .ADL_ADD(ADL_ADD),
    .SUMS(SUMS), .ANDS(ANDS), .EORS(EORS), .ORS(ORS), .SRS(SRS),
    .I_ADDC(I_ADDC), .DAA(DAA), .DSA(DSA),
    .Adder_Hold_Register_Out(out), .ACR(ACR), .AVR(AVR), .Result_Valid(Result_Valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // op: 0 sum, 1 and, 2 eor, 3 or, 4 shift-right
  task automatic ref_alu(input int a, b, op, c, daa, dsa, output int r, co, vo);
    int s, lo, t;
    s  = a + b + c;
    co = 0;
    vo = 0;
    case (op)
      0: begin
        r  = s % 256;
        co = s > 255;
        vo = (((a ^ b) & 8'h80) == 0) && (((a ^ r) & 8'h80) != 0);
`ifdef ALU_DECIMAL_MODE_EN
        lo = (a % 16) + (b % 16) + c;
        if (daa && !dsa) begin
          t = s;
          if (s % 16 > 9 || lo > 15) t += 6;
          co = (t > 8'h9F || s > 255);
          if (co) t += 8'h60;
          r = t % 256;
        end else if (dsa && !daa) begin
          t = s % 256 - (lo > 15 ? 0 : 6) - (s > 255 ? 0 : 8'h60);
          r = (t + 512) % 256;
        end
`else
        lo = 0;
        t  = 0;
`endif
      end
      1: r = a & b;
      2: r = a ^ b;
      3: r = a | b;
      default: begin
        t  = a & b;
        r  = c * 128 + t / 2;
        co = t % 2;
      end
    endcase
  endtask

  task automatic tick();
    int r, c, v;
    erv = pend;
    if (pend) begin
      ref_alu(ma, mb, pop, pcin, pdaa, pdsa, r, c, v);
      eo = r; ec = c; ev = v;
    end
    if (O_ADD) ma = 0; else if (SB_ADD) ma = SB;
    if (DB_ADD) mb = DB; else if (DB_N_ADD) mb = 255 - DB; else if (ADL_ADD) mb = ADL;
    pend = SUMS | ANDS | EORS | ORS | SRS;
    if (pend) begin
      pop  = SUMS ? 0 : ANDS ? 1 : EORS ? 2 : ORS ? 3 : 4;
      pcin = I_ADDC; pdaa = DAA; pdsa = DSA;
    end
    @(posedge clk); #1;
    chk("out", out, eo);
    chk("acr", ACR, ec);
    chk("avr", AVR, ev);
    chk("valid", Result_Valid, erv);
    {SB_ADD, O_ADD, DB_ADD, DB_N_ADD, ADL_ADD} = '0;
    {SUMS, ANDS, EORS, ORS, SRS, I_ADDC, DAA, DSA} = '0;
  endtask

  task automatic model_reset();
    ma = 0; mb = 0; pend = 0; eo = 0; ec = 0; ev = 0; erv = 0;
  endtask

  initial begin
    reset = 1; #2;
    chk("rst_out", out, 0); chk("rst_acr", ACR, 0); chk("rst_avr", AVR, 0); chk("rst_valid", Result_Valid, 0);
    @(posedge clk); #1; reset = 0;
    model_reset();
    tick();
    SB = 8'h50; DB = 8'h50; SB_ADD = 1; DB_ADD = 1; SUMS = 1; tick();
    chk("ovf_valid_early", Result_Valid, 0);
    tick();
    chk("ovf_out", out, 8'hA0); chk("ovf_acr", ACR, 0); chk("ovf_avr", AVR, 1); chk("ovf_valid", Result_Valid, 1);
    tick();
    chk("ovf_pulse", Result_Valid, 0);
    SB = 8'h10; DB = 8'h20; SB_ADD = 1; DB_N_ADD = 1; SUMS = 1; I_ADDC = 1; tick(); tick();
    chk("sub_out", out, 8'hF0); chk("sub_acr", ACR, 0); chk("sub_avr", AVR, 0);
    SB = 8'hF3; DB = 8'h0F; SB_ADD = 1; DB_ADD = 1; SRS = 1; I_ADDC = 1; tick();
    ANDS = 1; tick();
    chk("srs_out", out, 8'h81); chk("srs_acr", ACR, 1);
    tick();
    chk("and_out", out, 8'h03); chk("and_acr", ACR, 0);
    SB = 8'h45; DB = 8'h38; SB_ADD = 1; DB_ADD = 1; SUMS = 1; DAA = 1; tick(); tick();
`ifdef ALU_DECIMAL_MODE_EN
    chk("daa_out", out, 8'h83); chk("daa_acr", ACR, 0);
    SB = 8'h99; DB = 8'h01; SB_ADD = 1; DB_ADD = 1; SUMS = 1; DAA = 1; tick(); tick();
    chk("daa_wrap_out", out, 8'h00); chk("daa_wrap_acr", ACR, 1);
`else
    chk("bin_daa_out", out, 8'h7D);
`endif
    SB = 8'h01; DB = 8'h01; SB_ADD = 1; DB_ADD = 1; SUMS = 1; tick();
    SB = 8'hFF; SB_ADD = 1; SUMS = 1; tick();
    chk("b2b1_out", out, 8'h02); chk("b2b1_valid", Result_Valid, 1);
    tick();
    chk("b2b2_out", out, 8'h00); chk("b2b2_acr", ACR, 1); chk("b2b2_valid", Result_Valid, 1);
    SB = 8'h77; O_ADD = 1; SB_ADD = 1; ADL = 8'h3C; ADL_ADD = 1; ORS = 1; tick(); tick();
    chk("oadd_out", out, 8'h3C);
    SB = 8'h12; DB = 8'h34; SB_ADD = 1; DB_ADD = 1; SUMS = 1; tick();
    reset = 1; #1;
    chk("arst_out", out, 0); chk("arst_acr", ACR, 0); chk("arst_avr", AVR, 0); chk("arst_valid", Result_Valid, 0);
    @(posedge clk); #1; reset = 0;
    model_reset();
    tick();
    chk("post_rst_valid", Result_Valid, 0); chk("post_rst_out", out, 0);
    SB = 8'h05; DB = 8'h03; SB_ADD = 1; DB_ADD = 1; EORS = 1; tick(); tick();
    chk("clean_eor", out, 8'h06);
    for (int i = 0; i < 300; i++) begin
      SB = 8'($urandom); DB = 8'($urandom); ADL = 8'($urandom);
      {SB_ADD, O_ADD, DB_ADD, DB_N_ADD, ADL_ADD} = 5'($urandom);
      O_ADD &= ($urandom_range(0, 3) == 0);
      {SUMS, ANDS, EORS, ORS, SRS} = ($urandom_range(0, 4) == 0) ? 5'b0 : 5'($urandom);
      {I_ADDC, DAA, DSA} = 3'($urandom);
      tick();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
